// File: rtl/snd_pkg.sv
// snd_pkg: shared mode encoding and LFSR constants for the snd_gen sound generator.
`default_nettype none

package snd_pkg;

    typedef enum logic [1:0] {
        SND_OFF   = 2'd0,
        SND_TONE  = 2'd1,
        SND_SWEEP = 2'd2,
        SND_NOISE = 2'd3
    } snd_mode_e;

    localparam int LFSR_W = 15;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 15'h0001;
    localparam int TAP_HI = 14;
    localparam int TAP_LO = 13;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] l);
        return {l[LFSR_W-2:0], l[TAP_HI] ^ l[TAP_LO]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/snd_chan.sv
// snd_chan: one sound channel (half-period counter, tone/sweep/noise output bit).
// NOISE mode exists only when SND_GEN_NOISE_EN is defined; otherwise mode 3 acts as OFF.
`default_nettype none

module snd_chan
    import snd_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_sel,
    input  logic [1:0]       wr_mode,
    input  logic [CNT_W-1:0] wr_start,
    input  logic [CNT_W-1:0] wr_step,
    input  logic [CNT_W-1:0] wr_limit,
    output logic             out
);

    snd_mode_e        mode;
    logic [CNT_W-1:0] start;
    logic [CNT_W-1:0] step;
    logic [CNT_W-1:0] limit;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] cnt;
    logic             running;
    logic             evt;
    logic [CNT_W:0]   sweep_sum;
    logic [CNT_W-1:0] sweep_next;

`ifdef SND_GEN_NOISE_EN
    logic [LFSR_W-1:0] lfsr;
    logic [LFSR_W-1:0] lfsr_nx;
    assign lfsr_nx = lfsr_step(lfsr);
    assign running = (mode != SND_OFF);
`else
    assign running = (mode == SND_TONE) || (mode == SND_SWEEP);
`endif

    // One extra bit catches wrap-around so an overflowing sweep reloads start.
    always_comb begin
        sweep_sum  = {1'b0, period} + {1'b0, step};
        sweep_next = sweep_sum[CNT_W-1:0];
        if (sweep_sum[CNT_W] || (sweep_sum[CNT_W-1:0] > limit)) begin
            sweep_next = start;
        end
    end

    assign evt = running && (cnt == period);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode   <= SND_OFF;
            start  <= '0;
            step   <= '0;
            limit  <= '0;
            period <= '0;
            cnt    <= '0;
            out    <= 1'b0;
`ifdef SND_GEN_NOISE_EN
            lfsr   <= LFSR_SEED;
`endif
        end else if (wr_sel) begin
            // A write overrides any event due on the same edge.
            mode   <= snd_mode_e'(wr_mode);
            start  <= wr_start;
            step   <= wr_step;
            limit  <= wr_limit;
            period <= wr_start;
            cnt    <= '0;
            out    <= 1'b0;
`ifdef SND_GEN_NOISE_EN
            lfsr   <= LFSR_SEED;
`endif
        end else if (!running) begin
            cnt <= '0;
            out <= 1'b0;
        end else if (evt) begin
            cnt <= '0;
            case (mode)
                SND_TONE: begin
                    out <= ~out;
                end
                SND_SWEEP: begin
                    out    <= ~out;
                    period <= sweep_next;
                end
`ifdef SND_GEN_NOISE_EN
                SND_NOISE: begin
                    lfsr <= lfsr_nx;
                    out  <= lfsr_nx[0];
                end
`endif
                default: begin
                    out <= 1'b0;
                end
            endcase
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/snd_gen.sv
// snd_gen: N_CH-channel square/sweep/noise generator with write decode and popcount level.
// Optional NOISE mode is enabled by defining SND_GEN_NOISE_EN.
`default_nettype none

module snd_gen
    import snd_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int CNT_W = 16,
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int LVL_W = $clog2(N_CH + 1)
) (
    input  logic             i_Clk,
    input  logic             i_Rst_L,
    input  logic             i_Wr_En,
    input  logic [CH_W-1:0]  i_Wr_Ch,
    input  logic [1:0]       i_Wr_Mode,
    input  logic [CNT_W-1:0] i_Wr_Start,
    input  logic [CNT_W-1:0] i_Wr_Step,
    input  logic [CNT_W-1:0] i_Wr_Limit,
    output logic [N_CH-1:0]  o_Out,
    output logic [LVL_W-1:0] o_Level
);

    // Channel indices at or above N_CH never match, so such writes are dropped.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic wr_sel;
        assign wr_sel = i_Wr_En && (i_Wr_Ch == CH_W'(i));

        snd_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .clk      (i_Clk),
            .rst_n    (i_Rst_L),
            .wr_sel   (wr_sel),
            .wr_mode  (i_Wr_Mode),
            .wr_start (i_Wr_Start),
            .wr_step  (i_Wr_Step),
            .wr_limit (i_Wr_Limit),
            .out      (o_Out[i])
        );
    end

    always_comb begin
        o_Level = '0;
        for (int i = 0; i < N_CH; i++) begin
            o_Level = o_Level + LVL_W'(o_Out[i]);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_snd_gen.sv
// tb_snd_gen: randomized and directed stimulus for snd_gen against an in-bench channel model.
`default_nettype none

module tb_snd_gen;

    localparam int NCH = 3;
    localparam int CW  = 16;
`ifdef SND_GEN_NOISE_EN
    localparam bit NOISE_EN = 1'b1;
`else
    localparam bit NOISE_EN = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          wr_en;
    logic [1:0]    wr_ch;
    logic [1:0]    wr_mode;
    logic [CW-1:0] wr_start;
    logic [CW-1:0] wr_step;
    logic [CW-1:0] wr_limit;
    logic [NCH-1:0] out;
    logic [1:0]    level;

    int checks   = 0;
    int failures = 0;

    snd_gen #(.N_CH(NCH), .CNT_W(CW)) dut (
        .i_Clk      (clk),
        .i_Rst_L    (rst_n),
        .i_Wr_En    (wr_en),
        .i_Wr_Ch    (wr_ch),
        .i_Wr_Mode  (wr_mode),
        .i_Wr_Start (wr_start),
        .i_Wr_Step  (wr_step),
        .i_Wr_Limit (wr_limit),
        .o_Out      (out),
        .o_Level    (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: per-channel period/counter/output/LFSR as plain integers.
    int m_mode [NCH];
    int m_start[NCH];
    int m_step [NCH];
    int m_limit[NCH];
    int m_p    [NCH];
    int m_c    [NCH];
    int m_out  [NCH];
    int m_l    [NCH];

    function automatic bit m_active(input int md);
        return (md == 1) || (md == 2) || (NOISE_EN && md == 3);
    endfunction

    function automatic logic [NCH-1:0] m_vec();
        logic [NCH-1:0] v;
        for (int k = 0; k < NCH; k++) v[k] = (m_out[k] != 0);
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < NCH; k++) begin
            if (!rst_n) begin
                m_mode[k] = 0; m_start[k] = 0; m_step[k] = 0; m_limit[k] = 0;
                m_p[k] = 0; m_c[k] = 0; m_out[k] = 0; m_l[k] = 1;
            end else if (wr_en && int'(wr_ch) == k) begin
                m_mode[k] = int'(wr_mode); m_start[k] = int'(wr_start);
                m_step[k] = int'(wr_step); m_limit[k] = int'(wr_limit);
                m_p[k] = int'(wr_start); m_c[k] = 0; m_out[k] = 0; m_l[k] = 1;
            end else if (!m_active(m_mode[k])) begin
                m_c[k] = 0; m_out[k] = 0;
            end else if (m_c[k] != m_p[k]) begin
                m_c[k] = m_c[k] + 1;
            end else begin
                m_c[k] = 0;
                if (m_mode[k] == 1) begin
                    m_out[k] = 1 - m_out[k];
                end else if (m_mode[k] == 2) begin
                    int nxt;
                    m_out[k] = 1 - m_out[k];
                    nxt = m_p[k] + m_step[k];
                    m_p[k] = (nxt > m_limit[k]) ? m_start[k] : nxt;
                end else begin
                    int fb;
                    fb = ((m_l[k] >> 14) ^ (m_l[k] >> 13)) & 1;
                    m_l[k] = ((m_l[k] << 1) | fb) & 32'h7FFF;
                    m_out[k] = m_l[k] & 1;
                end
            end
        end
    end

    bit cmp_en = 1'b0;

    always @(negedge clk) begin
        if (cmp_en) begin
            checks++;
            if (out !== m_vec()) begin
                failures++;
                $display("FAIL out_vs_model t=%0t actual=%b expected=%b", $time, out, m_vec());
            end
            checks++;
            if (level !== 2'($countones(m_vec()))) begin
                failures++;
                $display("FAIL level_vs_model t=%0t actual=%0d expected=%0d", $time, level, $countones(m_vec()));
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the write edge.
    task automatic wr(input int ch, input int md, input int st, input int sp, input int lim);
        wr_en    = 1'b1;
        wr_ch    = 2'(ch);
        wr_mode  = 2'(md);
        wr_start = CW'(st);
        wr_step  = CW'(sp);
        wr_limit = CW'(lim);
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    int sw_exp[14] = '{0, 1, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1};

    initial begin
        bit found;
        rst_n = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_mode = '0;
        wr_start = '0; wr_step = '0; wr_limit = '0;
        idle(3);
        chk("reset_out", int'(out), 0);
        chk("reset_level", int'(level), 0);
        rst_n = 1'b1;
        cmp_en = 1'b1;
        idle(2);

        // TONE ch0 start=2: rises 3 cycles after the write, falls 3 later.
        wr(0, 1, 2, 0, 0);
        chk("tone_n0", int'(out[0]), 0);
        idle(2);
        chk("tone_n2", int'(out[0]), 0);
        idle(1);
        chk("tone_n3", int'(out[0]), 1);
        chk("tone_others", int'(out[2:1]), 0);
        idle(3);
        chk("tone_n6", int'(out[0]), 0);

        // SWEEP ch1 1/1/3: half-periods 2,3,4,2,3...
        wr(1, 2, 1, 1, 3);
        for (int n = 1; n <= 14; n++) begin
            idle(1);
            chk($sformatf("sweep_n%0d", n), int'(out[1]), sw_exp[n-1]);
        end

        // SWEEP with carry out: period stays 8, toggling every 9 cycles.
        wr(2, 2, 8, 16'hFFFC, 16'hFFFF);
        for (int n = 1; n <= 27; n++) begin
            idle(1);
            if (n == 8)  chk("carry_n8",  int'(out[2]), 0);
            if (n == 9)  chk("carry_n9",  int'(out[2]), 1);
            if (n == 17) chk("carry_n17", int'(out[2]), 1);
            if (n == 18) chk("carry_n18", int'(out[2]), 0);
            if (n == 27) chk("carry_n27", int'(out[2]), 1);
        end

        // Write to ch0 on the edge of a pending rising toggle: write wins.
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            if (m_mode[0] == 1 && m_c[0] == m_p[0] && m_out[0] == 0) found = 1'b1;
            else idle(1);
        end
        chk("collide_found", int'(found), 1);
        wr(0, 1, 2, 0, 0);
        chk("collide_out", int'(out[0]), 0);
        chk("collide_cnt", int'(dut.g_ch[0].u_chan.cnt), 0);

        // Out-of-range channel write is ignored.
        wr(0, 0, 0, 0, 0);
        wr(1, 0, 0, 0, 0);
        wr(2, 0, 0, 0, 0);
        wr(3, 1, 0, 0, 0);
        for (int n = 0; n < 4; n++) begin
            chk("badch_quiet", int'(out), 0);
            idle(1);
        end

        // All channels TONE start=0 in phase: level alternates 0/3.
        wr(0, 1, 0, 0, 0);
        idle(1);
        wr(1, 1, 0, 0, 0);
        idle(1);
        wr(2, 1, 0, 0, 0);
        chk("all_lvl0", int'(level), 0);
        idle(1);
        chk("all_lvl1", int'(level), 3);
        idle(1);
        chk("all_lvl2", int'(level), 0);
        idle(1);
        chk("all_lvl3", int'(level), 3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_out", int'(out), 0);
        chk("async_rst_level", int'(level), 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Randomized writes, checked each cycle against the model.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                int st, sp, lim;
                if ($urandom_range(0, 7) == 0) begin
                    st = int'($urandom_range(16'hFFE0, 16'hFFFF));
                    sp = int'($urandom_range(0, 16'h0040));
                    lim = int'($urandom_range(16'hFFF0, 16'hFFFF));
                end else begin
                    st = int'($urandom_range(0, 5));
                    sp = int'($urandom_range(0, 3));
                    lim = int'($urandom_range(0, 9));
                end
                wr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), st, sp, lim);
            end else begin
                idle(1);
            end
        end

        // NOISE ch2, start=0: one event per cycle; first 1 appears at event 14.
        wr(2, 3, 0, 0, 0);
        idle(13);
        chk("noise_ev13", int'(out[2]), 0);
        idle(1);
        chk("noise_ev14", int'(out[2]), NOISE_EN ? 1 : 0);
        idle(32767 - 14);
`ifdef SND_GEN_NOISE_EN
        chk("noise_wrap_dut", int'(dut.g_ch[2].u_chan.lfsr), 1);
        chk("noise_wrap_model", m_l[2], 1);
`else
        chk("noise_off_out", int'(out[2]), 0);
`endif
        idle(2);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/snd_gen.md
# snd_gen

Multi-channel square/sweep/noise sound generator: the parametrised successor of the single-channel sweep tone builtin. Each of N_CH independent channels runs a half-period counter and drives a 1-bit audio output in one of four modes: off, fixed tone, linear period sweep with wrap, or LFSR noise. A single-cycle write port configures the channels. A popcount output provides a mixed level for a downstream DAC or PWM stage.

## Interface
- N_CH, 4: number of channels, 1..16
- CNT_W, 16: width of the counter, period, step and limit fields
- i_Clk  in  1  system clock; all state updates on the rising edge
- i_Rst_L  in  1  asynchronous active-low reset
- i_Wr_En  in  1  configuration write strobe, one cycle
- i_Wr_Ch  in  max(1,$clog2(N_CH))  target channel
- i_Wr_Mode  in  2  mode: 0 OFF, 1 TONE, 2 SWEEP, 3 NOISE
- i_Wr_Start  in  CNT_W  initial half-period value
- i_Wr_Step  in  CNT_W  sweep increment (SWEEP only)
- i_Wr_Limit  in  CNT_W  sweep upper bound (SWEEP only)
- o_Out  out  N_CH  per-channel audio bit, registered
- o_Level  out  $clog2(N_CH+1)  count of set o_Out bits

## Operation
- Per-channel state: mode, start, step, limit, current period P, counter C, output bit, 15-bit LFSR L.
- Reset: mode OFF; P, C, start, step and limit all 0; o_Out all 0; L = package seed 15'h0001; o_Level 0.
- Write with i_Wr_En=1 and i_Wr_Ch < N_CH:
  - loads mode, start, step and limit;
  - P←start, C←0, output←0, L←seed.
  - A write with i_Wr_Ch ≥ N_CH is ignored.
- OFF: C held at 0, output held at 0.
- Every other mode, each cycle: if C == P, an event occurs and C←0; otherwise C←C+1.
- Event in TONE: output toggles.
- Event in SWEEP:
  - output toggles;
  - next = P + step, computed CNT_W+1 wide;
  - if next > limit or the carry is set, P←start; otherwise P←next.
- Event in NOISE:
  - L←{L[13:0], L[14]^L[13]};
  - output←new L[0];
  - P unchanged.
- o_Level is the combinational popcount of o_Out.

## Timing
- Half-period is P+1 cycles. P=0 toggles every cycle.
- A write takes effect at the next edge. The first event comes P+1 cycles after the write edge.
- A write and an event on the same channel in the same cycle: the write wins, and the event is discarded.
- Writes to different channels are independent. Only one channel is written per cycle.
- start > limit in SWEEP: the first event reloads start, so the channel behaves as TONE at start.
- Reset asserted mid-operation clears all state immediately, regardless of clock.
- Release is synchronous to the clock in practice: the first count occurs at the first edge after deassertion.
- The LFSR never reaches 0 and repeats every 32767 events.

## Configuration
- Macro SND_GEN_NOISE_EN.
- Defined: NOISE mode as described, with one LFSR per channel.
- Undefined: no LFSR is instantiated; mode 3 behaves exactly as OFF (output 0, counter held at 0).

## Structure
- Package snd_pkg holds:
  - the mode enum (SND_OFF, SND_TONE, SND_SWEEP, SND_NOISE);
  - LFSR width 15;
  - the seed 15'h0001;
  - the tap positions 14 and 13.
- Sub-module snd_chan: one channel holding all per-channel state, generated N_CH times.
- The top level holds write decode and the popcount.

## Test plan
- Reset, then TONE ch0 with start=2 → o_Out[0] toggles every 3 cycles (period 6); other channels stay 0; o_Level alternates 0/1.
- SWEEP ch1 with start=1, step=1, limit=3 → half-periods of 2,3,4,2,3,4… cycles.
- SWEEP with start=16'hFFF0, step=16'h0020, limit=16'hFFFF → carry forces P back to 16'hFFF0 after every event.
- NOISE ch2 with start=0 → output follows L[0] each cycle, starting 0,0,…; after 32767 events L == 15'h0001 and is never 0. With SND_GEN_NOISE_EN undefined, the output stays 0.
- Write to ch0 in the same cycle as its toggle → no toggle, C=0 and output 0 next cycle. A write with i_Wr_Ch=N_CH (N_CH=4 → 4 requires CH width 3; use N_CH=3) → no state change.
- All four channels in TONE at start=0 → o_Level steps 0→4→0. i_Rst_L pulsed low mid-count → all outputs 0 and o_Level 0 immediately.
